// File: rtl/history_match_pkg.sv
// Shared types for the history match buffer: search FSM states and the
// result record produced by the scanner.
package history_match_pkg;

    // Widest index the shared result record can carry (DEPTH up to 2**16).
    localparam int MAX_AW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic              hit;
        logic [MAX_AW-1:0] idx;
        logic [MAX_AW:0]   count;
    } result_t;

endpackage

// File: rtl/history_match_scanner.sv
// Compare/count datapath: holds the query key and accumulates hit, first
// matching index and match count while the FSM steps through the buffer.
module history_match_scanner
    import history_match_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] key_in,
    input  logic             step,
    input  logic [AW-1:0]    cmp_idx,
    input  logic [WIDTH-1:0] cmp_data,
    output logic             hit,
    output logic [AW-1:0]    idx,
    output logic [AW:0]      count
);

    localparam logic [MAX_AW:0] CNT_ONE = 1;

    logic [WIDTH-1:0] key;
    result_t          res;
    logic             match;

    assign match = step && (cmp_data == key);

    // Capture the searched value when a query is accepted.
    always_ff @(posedge clk) begin
        if (start) begin
            key <= key_in;
        end
    end

    // Clear on a new query; record the first match index, count every match.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            res <= '0;
        end else if (match) begin
            if (!res.hit) begin
                res.hit <= 1'b1;
                res.idx <= MAX_AW'(cmp_idx);
            end
            res.count <= res.count + CNT_ONE;
        end
    end

    assign hit   = res.hit;
    assign idx   = res.idx[AW-1:0];
    assign count = res.count[AW:0];

    // The shared record is wider than this instance needs; upper bits stay zero.
    logic unused_res_bits;
    assign unused_res_bits = ^res;

endmodule

// File: rtl/history_match_buffer.sv
// Circular history buffer with a zero-latency read port and a sequential
// membership search that scans one entry per cycle.
module history_match_buffer
    import history_match_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      fill_count,
    output logic             full,
    input  logic             query_valid,
    output logic             query_ready,
    input  logic [WIDTH-1:0] query_data,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             result_hit,
    output logic [AW-1:0]    result_idx,
    output logic [AW:0]      result_count
);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    state_t           state;
    logic [AW-1:0]    scan_idx;
    logic [AW:0]      scan_n;
    logic             accept;
    logic             scan_last;

    assign query_ready = (state == IDLE);
    assign accept      = query_valid && query_ready && !rst;
    assign scan_last   = ({1'b0, scan_idx} == (scan_n - CNT_ONE));
    assign full        = (fill_count == CNT_FULL);
    assign rd_data     = mem[rd_addr];

    // Storage write; contents are never cleared, reset only blocks the write.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Write pointer wraps naturally; fill count saturates once the ring is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            fill_count <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (fill_count != CNT_FULL) begin
                fill_count <= fill_count + CNT_ONE;
            end
        end
    end

    // Search FSM: snapshot the entry count, walk indices 0..N-1, then present
    // the result one cycle after entering DONE and hold it until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            scan_idx     <= '0;
            scan_n       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        scan_n   <= fill_count;
                        scan_idx <= '0;
                        state    <= (fill_count == '0) ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    scan_idx <= scan_idx + PTR_ONE;
                    if (scan_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (result_valid && result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                    end else begin
                        result_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Compare path reads the entry as stored before any same-cycle write.
    history_match_scanner #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_scanner (
        .clk      (clk),
        .rst      (rst),
        .start    (accept),
        .key_in   (query_data),
        .step     (state == SCAN),
        .cmp_idx  (scan_idx),
        .cmp_data (mem[scan_idx]),
        .hit      (result_hit),
        .idx      (result_idx),
        .count    (result_count)
    );

endmodule
